// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared types for the PC redirect control path: PC select encoding,
// redirect FSM states and the machine word.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    PC_SEQ      = 2'b00,
    PC_REDIRECT = 2'b01,
    PC_HOLD     = 2'b10
  } pcselect_t;

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    HALTED
  } redir_state_t;

endpackage

// File: rtl/pc_redirect_ctrl_if.sv
// PC port bundle: the controller side drives select/target, the PC side
// returns the current fetch address.
interface pc_if;
  import cpu_types_pkg::*;

  pcselect_t pc_select;
  word_t     jump_data;
  word_t     imem_addr;

  modport pcctrl (output pc_select, jump_data, input imem_addr);
  modport pc     (input pc_select, jump_data, output imem_addr);

endinterface

// File: rtl/pc_redirect_ctrl_branch_target_calc.sv
// Resolves whether the EX-stage control transfer is taken and where it goes.
// When more than one of jr/j/br is set, jr wins over j, which wins over br.
module branch_target_calc
  import cpu_types_pkg::*;
(
  input  logic        ex_valid,
  input  logic        ex_br,
  input  logic        ex_bne,
  input  logic        ex_zero,
  input  logic        ex_j,
  input  logic        ex_jr,
  input  word_t       ex_pcplus4,
  input  logic [15:0] ex_imm,
  input  logic [25:0] ex_jaddr,
  input  word_t       ex_rsdata,
  output logic        taken,
  output word_t       target
);

  word_t br_offset;

  // Word offset to byte offset; the add wraps silently at 2^32.
  assign br_offset = {{14{ex_imm[15]}}, ex_imm, 2'b00};

  assign taken = ex_valid & (ex_jr | ex_j | (ex_br & (ex_zero ^ ex_bne)));

  always_comb begin
    target = ex_pcplus4 + br_offset;
    if (ex_jr) begin
      target = ex_rsdata;
    end else if (ex_j) begin
      target = {ex_pcplus4[31:28], ex_jaddr, 2'b00};
    end
  end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Predict-not-taken redirect controller: resolves EX control transfers, holds a
// target until the PC accepts it, flushes, stalls EX, and counts redirects.
module pc_redirect_ctrl
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             pc_advance,
  input  logic             halt,
  input  logic             ex_valid,
  input  logic             ex_br,
  input  logic             ex_bne,
  input  logic             ex_zero,
  input  logic             ex_j,
  input  logic             ex_jr,
  input  word_t            ex_pcplus4,
  input  logic [15:0]      ex_imm,
  input  logic [25:0]      ex_jaddr,
  input  word_t            ex_rsdata,
  pc_if.pcctrl             pc_bus,
  output logic             flush,
  output logic             redirect_busy,
  output logic [CNT_W-1:0] redirect_count
);

  redir_state_t state_q, state_d;
  word_t        target_q;
  word_t        target;
  logic         taken;
  logic         count_inc;

  branch_target_calc u_calc (
    .ex_valid   (ex_valid),
    .ex_br      (ex_br),
    .ex_bne     (ex_bne),
    .ex_zero    (ex_zero),
    .ex_j       (ex_j),
    .ex_jr      (ex_jr),
    .ex_pcplus4 (ex_pcplus4),
    .ex_imm     (ex_imm),
    .ex_jaddr   (ex_jaddr),
    .ex_rsdata  (ex_rsdata),
    .taken      (taken),
    .target     (target)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q        <= IDLE;
      target_q       <= '0;
      redirect_count <= '0;
    end else begin
      state_q <= state_d;
      if (halt) begin
        target_q <= '0;
      end else if (state_q == IDLE && taken && !pc_advance) begin
        target_q <= target;
      end
      if (count_inc) begin
        redirect_count <= redirect_count + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (halt) begin
      state_d = HALTED;
    end else begin
      case (state_q)
        IDLE:    if (taken && !pc_advance) state_d = PENDING;
        PENDING: if (pc_advance) state_d = IDLE;
        HALTED:  state_d = HALTED;
        default: state_d = IDLE;
      endcase
    end
  end

  // A retiring halt freezes the PC in its own cycle and cancels any redirect.
  always_comb begin
    pc_bus.pc_select = PC_HOLD;
    pc_bus.jump_data = '0;
    flush            = 1'b0;
    redirect_busy    = 1'b0;
    count_inc        = 1'b0;
    if (!RST && !halt) begin
      case (state_q)
        IDLE: begin
          if (taken && pc_advance) begin
            pc_bus.pc_select = PC_REDIRECT;
            pc_bus.jump_data = target;
            flush            = 1'b1;
            count_inc        = 1'b1;
          end else if (!taken) begin
            pc_bus.pc_select = PC_SEQ;
          end
        end
        PENDING: begin
          pc_bus.pc_select = PC_REDIRECT;
          pc_bus.jump_data = target_q;
          redirect_busy    = 1'b1;
          flush            = pc_advance;
          count_inc        = pc_advance;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/pc_redirect_ctrl.md
Name: pc_redirect_ctrl

Overview:
- Drives the control side of the PC port: produces pc_select and jump_data for the PC block, which consumes them and returns imem_addr.
- Resolves branch, jump and jr outcomes from the EX stage under a predict-not-taken policy.
- If the PC cannot update in the same cycle, the target is held in a pending register until the PC accepts it.
- Issues a pipeline flush, stalls EX while a redirect is pending, handles halt, and counts redirects.

Parameters:
- CNT_W, 32, width of the redirect counter.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  synchronous reset, active-high.
- pc_advance  input  1  PC updates at this edge (ihit & ~stall).
- halt  input  1  halt instruction retired; freeze PC.
- ex_valid  input  1  EX holds a valid instruction.
- ex_br  input  1  EX instruction is a conditional branch.
- ex_bne  input  1  branch is BNE (0 = BEQ).
- ex_zero  input  1  ALU zero flag.
- ex_j  input  1  J or JAL.
- ex_jr  input  1  JR.
- ex_pcplus4  input  32  PC+4 of the EX instruction.
- ex_imm  input  16  branch offset, in words.
- ex_jaddr  input  26  jump index.
- ex_rsdata  input  32  forwarded rs value.
- pc_select  output  pcselect_t (2)  SEQ / REDIRECT / HOLD to the PC.
- jump_data  output  32  redirect target.
- flush  output  1  squash IF/ID and ID/EX this edge.
- redirect_busy  output  1  freeze EX; a redirect is pending.
- redirect_count  output  CNT_W  number of redirects accepted by the PC.

Behaviour:
- Interface: one clock (CLK); reset RST is synchronous and active-high.
- Reset (RST=1 at an edge): state IDLE, target_q=0, redirect_count=0.
- While RST=1, outputs are forced: pc_select=HOLD, jump_data=0, flush=0, redirect_busy=0.
- taken = ex_valid & (ex_jr | ex_j | (ex_br & (ex_zero ^ ex_bne))).
- Target priority: jr > j > br. Combinations with more than one of these set are illegal, but the priority is still applied.
  - jr: ex_rsdata.
  - j: {ex_pcplus4[31:28], ex_jaddr, 2'b00}.
  - br: ex_pcplus4 + (sign-extended ex_imm << 2), modulo 2^32; wrap-around is not flagged.
- States: IDLE, PENDING, HALTED.
- IDLE:
  - Outputs are combinational from the EX inputs.
  - taken & pc_advance: pc_select=REDIRECT, jump_data=target, flush=1, count+1; stay IDLE.
  - taken & ~pc_advance: pc_select=HOLD, flush=0, busy=0; latch target_q; go to PENDING.
  - Otherwise: pc_select=SEQ, jump_data=0, flush=0.
- PENDING:
  - Outputs: pc_select=REDIRECT, jump_data=target_q, redirect_busy=1, flush=pc_advance.
  - On pc_advance: count+1, go to IDLE.
  - EX inputs are ignored, since EX is frozen by redirect_busy.
- HALTED:
  - pc_select=HOLD, flush=0, busy=0.
  - Exit only by reset.
- halt=1 in any state: go to HALTED at the next edge and drop any pending target.
  - A redirect in the same cycle is not taken, and count does not increment.
- Latency:
  - Redirect accepted in the same cycle as resolution when pc_advance=1.
  - Otherwise accepted at the first cycle with pc_advance=1; there is no timeout.
- redirect_count wraps modulo 2^CNT_W.
- Reset asserted mid-PENDING: the target is discarded and the block returns to IDLE.

Decomposition:
- cpu_types_pkg holds:
  - pcselect_t enum: PC_SEQ=2'b00, PC_REDIRECT=2'b01, PC_HOLD=2'b10.
  - redir_state_t enum: IDLE, PENDING, HALTED.
  - word_t.
- pc_redirect_ctrl holds the FSM and counter.
- One combinational sub-module, branch_target_calc, computes taken and target from the EX inputs.
- Outputs are bundled into pc_if via a new modport pcctrl (output pc_select, jump_data; input imem_addr) for the control side of the PC interface.

Test Plan:
- BEQ, ex_zero=1, ex_pcplus4=0x0000_0104, ex_imm=0xFFFE, pc_advance=1 -> same cycle: REDIRECT, jump_data=0x0000_00FC, flush=1, count=1.
- BNE, ex_zero=1 -> not taken: pc_select=SEQ, flush=0, count unchanged.
- J, ex_pcplus4=0x4000_0010, ex_jaddr=0x000_0040, pc_advance=0 for 3 cycles, then 1:
  - First cycle: HOLD.
  - Next 3 cycles: REDIRECT, jump_data=0x4000_0100, busy=1, flush=0.
  - Accept edge: flush=1, then IDLE, count+1.
- JR with ex_j=1, ex_rsdata=0x0000_2000 -> jump_data=0x0000_2000 (jr priority).
- Halt while PENDING -> next cycle HALTED: HOLD, busy=0; pc_advance pulses do not change count.
- BEQ offset 0x7FFF with ex_pcplus4=0xFFFF_FFF0 -> target 0x0001_FFEC (wrap). RST mid-PENDING -> IDLE, outputs at reset values, count=0.
